alu_arbiter: RTL and testbench

- Shares the single 8-bit combinational ALU (add/sub/and/or, 2-bit op) between two requesters, e.g. the core datapath (port 0) and an address/auxiliary unit (port 1).
- Per requester: valid/ready request channel and valid/ready response channel.
- Drives the ALU operand and op inputs from registers.
- Captures the ALU result and zero flag into a response register.
- Sits between the requesters and the ALU instance; the ALU itself is instantiated outside this block.

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU: registers the granted
// operands, waits one cycle for the ALU to settle, and holds the result until the requester takes it.
module alu_arbiter #(
    parameter int DATA_W     = 8,
    parameter int OP_W       = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic [7:0]        op_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam bit FIXED = (FIXED_PRIO != 0);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_id_q, grant_id_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic [7:0]        op_count_q, op_count_d;

    logic grant;
    logic any_valid;
    logic rsp_fire;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Request ready is only offered in IDLE to the granted port; response valid is only
    // raised in RESP for the port that owns the operation, and rsp_data/rsp_zero stay
    // stable until that response is taken.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = FIXED ? 1'b0 : ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = (state_q == IDLE) && req1_valid && grant;
    assign rsp0_valid = (state_q == RESP) && !grant_id_q;
    assign rsp1_valid = (state_q == RESP) && grant_id_q;
    assign rsp_fire   = (state_q == RESP) && (grant_id_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        op_count_d   = op_count_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    alu_a_d      = grant ? req1_a  : req0_a;
                    alu_b_d      = grant ? req1_b  : req0_b;
                    alu_op_d     = grant ? req1_op : req0_op;
                    grant_id_d   = grant;
                    last_grant_d = grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // Operands have been stable at the ALU for a full cycle here.
                rsp_data_d = alu_result;
                rsp_zero_d = alu_zero;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_fire) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            op_count_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority
// instance, each wired to a behavioural ALU.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Round-robin instance signals
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp_data, alu_a, alu_b, alu_result, op_count;
    logic       rsp_zero, alu_zero, busy;
    logic [1:0] alu_op, dbg_state;

    // Fixed-priority instance signals
    logic       f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
    logic [7:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
    logic [1:0] f_req0_op, f_req1_op;
    logic       f_rsp0_valid, f_rsp0_ready, f_rsp1_valid, f_rsp1_ready;
    logic [7:0] f_rsp_data, f_alu_a, f_alu_b, f_alu_result, f_op_count;
    logic       f_rsp_zero, f_alu_zero, f_busy;
    logic [1:0] f_alu_op, f_dbg_state;

    alu_arbiter #(.DATA_W(8), .OP_W(2), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
    );

    alu_arbiter #(.DATA_W(8), .OP_W(2), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready),
        .req0_a(f_req0_a), .req0_b(f_req0_b), .req0_op(f_req0_op),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready),
        .req1_a(f_req1_a), .req1_b(f_req1_b), .req1_op(f_req1_op),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready),
        .rsp_data(f_rsp_data), .rsp_zero(f_rsp_zero),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_op(f_alu_op),
        .alu_result(f_alu_result), .alu_zero(f_alu_zero),
        .busy(f_busy), .op_count(f_op_count), .dbg_state(f_dbg_state)
    );

    // External ALU: 00 add, 01 sub, 10 and, 11 or
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
        alu_zero = (alu_result == 8'h00);
        case (f_alu_op)
            2'b00:   f_alu_result = f_alu_a + f_alu_b;
            2'b01:   f_alu_result = f_alu_a - f_alu_b;
            2'b10:   f_alu_result = f_alu_a & f_alu_b;
            default: f_alu_result = f_alu_a | f_alu_b;
        endcase
        f_alu_zero = (f_alu_result == 8'h00);
    end

    typedef struct {
        logic       port;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp_data;
        logic       exp_zero;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;
    logic [7:0] exp_count = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One uncontended operation on the round-robin instance, consumer ready at once
    task automatic do_op(input vec_t v);
        @(negedge clk);
        if (v.port) begin
            req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
        end else begin
            req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
        end
        #1;
        chk("req_ready", {req1_ready, req0_ready}, v.port ? 2 : 1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_alu_a", alu_a, v.a);
        chk("exec_alu_b", alu_b, v.b);
        chk("exec_alu_op", alu_op, v.op);
        chk("exec_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        @(negedge clk); #1;
        chk("rsp_valid", {rsp1_valid, rsp0_valid}, v.port ? 2 : 1);
        chk("rsp_data", rsp_data, v.exp_data);
        chk("rsp_zero", rsp_zero, v.exp_zero);
        if (v.port) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        exp_count++;
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk("done_busy", busy, 0);
        chk("done_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("op_count", op_count, exp_count);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 8'h05, 8'h03, 2'b00, 8'h08, 1'b0};
        vecs[1] = '{1'b1, 8'h20, 8'h20, 2'b01, 8'h00, 1'b1};
        vecs[2] = '{1'b1, 8'h00, 8'h01, 2'b01, 8'hFF, 1'b0};
        vecs[3] = '{1'b0, 8'hF0, 8'h3C, 2'b10, 8'h30, 1'b0};
        vecs[4] = '{1'b0, 8'hF0, 8'h0F, 2'b11, 8'hFF, 1'b0};
        vecs[5] = '{1'b1, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 2'b11, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 8'hAA, 8'h55, 2'b10, 8'h00, 1'b1};

        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0; rsp0_ready = 0; rsp1_ready = 0;
        f_req0_valid = 0; f_req1_valid = 0; f_req0_a = 0; f_req0_b = 0; f_req0_op = 0;
        f_req1_a = 0; f_req1_b = 0; f_req1_op = 0; f_rsp0_ready = 0; f_rsp1_ready = 0;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_rsp", {rsp1_valid, rsp0_valid, rsp_zero, rsp_data}, 0);
        chk("rst_alu", {alu_op, alu_b, alu_a}, 0);
        chk("rst_req_ready", {req1_ready, req0_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) do_op(vecs[i]);

        // Round robin: last grant was port 1, so contention goes 0,1,0,1
        @(negedge clk);
        req0_valid = 1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 2'b10;
        req1_valid = 1; req1_a = 8'hF0; req1_b = 8'h0F; req1_op = 2'b11;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("rr_grant", {req1_ready, req0_ready}, (k % 2) ? 2 : 1);
            @(negedge clk);
            @(negedge clk); #1;
            chk("rr_rsp_valid", {rsp1_valid, rsp0_valid}, (k % 2) ? 2 : 1);
            chk("rr_rsp_data", rsp_data, (k % 2) ? 8'hFF : 8'h30);
            exp_count++;
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk); #1;
        chk("rr_op_count", op_count, exp_count);
        rsp0_ready = 0; rsp1_ready = 0;

        // Backpressure on port 0 while port 1 waits
        @(negedge clk);
        req0_valid = 1; req0_a = 8'h12; req0_b = 8'h34; req0_op = 2'b00;
        req1_valid = 1; req1_a = 8'h07; req1_b = 8'h09; req1_op = 2'b01;
        #1;
        chk("bp_grant", {req1_ready, req0_ready}, 1);
        @(negedge clk);
        req0_valid = 0;
        #1;
        chk("bp_exec_req1_ready", req1_ready, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_rsp_data", rsp_data, 8'h46);
            chk("bp_busy", busy, 1);
            chk("bp_req1_ready", req1_ready, 0);
        end
        rsp0_ready = 1;
        exp_count++;
        @(negedge clk); #1;
        chk("bp_idle_busy", busy, 0);
        chk("bp_req1_accept", {req1_ready, req0_ready}, 2);
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk); #1;
        chk("bp_rsp1_valid", {rsp1_valid, rsp0_valid}, 2);
        chk("bp_rsp1_data", rsp_data, 8'hFE);
        chk("bp_rsp1_zero", rsp_zero, 0);
        // rsp0_ready still high but ignored while rsp0_valid is low
        @(negedge clk); #1;
        chk("bp_hold_rsp1", {busy, rsp1_valid}, 2'b11);
        chk("bp_hold_count", op_count, exp_count);
        rsp1_ready = 1;
        exp_count++;
        @(negedge clk); #1;
        chk("bp_done_count", op_count, exp_count);
        chk("bp_done_busy", busy, 0);
        rsp0_ready = 0; rsp1_ready = 0;

        // Fixed priority: port 0 wins three times, port 1 only after port 0 drops
        @(negedge clk);
        f_req0_valid = 1; f_req0_a = 8'h01; f_req0_b = 8'h02; f_req0_op = 2'b00;
        f_req1_valid = 1; f_req1_a = 8'h10; f_req1_b = 8'h01; f_req1_op = 2'b01;
        f_rsp0_ready = 1; f_rsp1_ready = 1;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("fp_grant0", {f_req1_ready, f_req0_ready}, 1);
            @(negedge clk);
            @(negedge clk); #1;
            chk("fp_rsp0", {f_rsp1_valid, f_rsp0_valid}, 1);
            chk("fp_rsp0_data", f_rsp_data, 8'h03);
        end
        f_req0_valid = 0;
        @(negedge clk); #1;
        chk("fp_grant1", {f_req1_ready, f_req0_ready}, 2);
        @(negedge clk);
        f_req1_valid = 0;
        @(negedge clk); #1;
        chk("fp_rsp1", {f_rsp1_valid, f_rsp0_valid}, 2);
        chk("fp_rsp1_data", f_rsp_data, 8'h0F);
        @(negedge clk); #1;
        chk("fp_op_count", f_op_count, 4);
        f_rsp0_ready = 0; f_rsp1_ready = 0;

        // Reset during EXEC of a port 0 operation (last grant becomes 0)
        @(negedge clk);
        req0_valid = 1; req0_a = 8'h33; req0_b = 8'h11; req0_op = 2'b01;
        @(negedge clk);
        req0_valid = 0;
        #1;
        chk("mid_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp", {rsp1_valid, rsp0_valid, rsp_zero, rsp_data}, 0);
        chk("mid_rst_count", op_count, 0);
        chk("mid_rst_alu", {alu_op, alu_b, alu_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("post_rst_no_rsp", {busy, rsp1_valid, rsp0_valid}, 0);
        end
        @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("post_rst_grant", {req1_ready, req0_ready}, 1);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
